// File: rtl/uart_hex_word_assembler_if.sv
// uart_hex_word_assembler_if
//   Bundles the byte stream coming from uart_rx and the word handshake going
//   to the operand consumer, together with the assembler's status flags.
//
//   Signals:
//     rx_valid     one-cycle byte strobe from uart_rx
//     rx_data      received ASCII byte, valid while rx_valid is high
//     word_ready   consumer can take word_data this cycle
//     word_valid   word_data holds a complete word
//     word_data    assembled word, first digit received in the MSBs
//     digit_count  digits collected for the current word (0..NUM_DIGITS)
//     err_pulse    one-cycle pulse after an illegal character
//     overrun      sticky, a byte was dropped while a word was waiting
//
//   Modports:
//     master  the assembler itself
//     slave   the surrounding logic (uart_rx side plus the word consumer)
interface uart_hex_word_assembler_if #(
    parameter int NUM_DIGITS = 8
);
    localparam int WORD_W = 4 * NUM_DIGITS;

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              word_ready;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic [3:0]        digit_count;
    logic              err_pulse;
    logic              overrun;

    modport master (
        input  rx_valid,
        input  rx_data,
        input  word_ready,
        output word_valid,
        output word_data,
        output digit_count,
        output err_pulse,
        output overrun
    );

    modport slave (
        output rx_valid,
        output rx_data,
        output word_ready,
        input  word_valid,
        input  word_data,
        input  digit_count,
        input  err_pulse,
        input  overrun
    );
endinterface

// File: rtl/uart_hex_word_assembler.sv
// uart_hex_word_assembler
//   Decodes ASCII hex characters arriving from uart_rx and packs NUM_DIGITS
//   nibbles, most significant first, into one word offered on a valid/ready
//   handshake. Illegal characters clear the partial word and raise a
//   one-cycle err_pulse; bytes arriving while a finished word waits are
//   dropped and recorded in the sticky overrun flag.
//
//   Parameters:
//     NUM_DIGITS  hex digits per word, 1..8
//     WORD_W      4*NUM_DIGITS, derived
//
//   Ports:
//     clk   system clock
//     rst   synchronous active-high reset
//     bus   uart_hex_word_assembler_if.master (byte input, word output, status)
//
//   Build option:
//     HEXW_TERM_EN  when defined, CR/LF after at least one digit finishes the
//                   word early (right-justified). When undefined, CR/LF in
//                   COLLECT are ignored and only NUM_DIGITS digits make a word.
module uart_hex_word_assembler #(
    parameter  int NUM_DIGITS = 8,
    localparam int WORD_W     = 4 * NUM_DIGITS
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_hex_word_assembler_if.master   bus
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q,  word_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic              err_q,   err_d;
    logic              ovr_q,   ovr_d;

    // ------------------------------------------------------------------
    // Character decode
    // ------------------------------------------------------------------
    logic       is_hex;
    logic       is_term;
    logic [3:0] nib;

    always_comb begin
        is_hex  = 1'b0;
        nib     = 4'd0;
        is_term = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
        if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
            is_hex = 1'b1;
            nib    = bus.rx_data[3:0];
        end else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                     (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66)) begin
            // Low nibble of 'A'..'F' / 'a'..'f' is 1..6, so add 9 for 10..15.
            is_hex = 1'b1;
            nib    = bus.rx_data[3:0] + 4'd9;
        end
    end

    // ------------------------------------------------------------------
    // Byte processing works on a "base" word/count: the live register in
    // COLLECT, or an empty word when a transfer happens in the same cycle
    // so that the incoming byte starts the next word instead of being lost.
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] base_word;
    logic [3:0]        base_cnt;
    logic [3:0]        next_cnt;
    logic [WORD_W-1:0] shifted;
    logic              take;

    assign next_cnt = base_cnt + 4'd1;

    if (NUM_DIGITS == 1) begin : g_single
        assign shifted = nib;
    end else begin : g_multi
        assign shifted = {base_word[WORD_W-5:0], nib};
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        ovr_d     = ovr_q;
        base_word = word_q;
        base_cnt  = cnt_q;
        take      = 1'b0;

        case (state_q)
            COLLECT: begin
                take = 1'b1;
            end
            HOLD: begin
                if (bus.word_ready) begin
                    state_d   = COLLECT;
                    word_d    = '0;
                    cnt_d     = 4'd0;
                    base_word = '0;
                    base_cnt  = 4'd0;
                    take      = 1'b1;
                end else if (bus.rx_valid) begin
                    // Word still waiting: byte is dropped, never flagged as
                    // illegal, only remembered as an overrun.
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        if (take && bus.rx_valid) begin
            if (is_hex) begin
                word_d = shifted;
                cnt_d  = next_cnt;
                if (next_cnt == 4'(NUM_DIGITS))
                    state_d = HOLD;
            end else if (is_term) begin
`ifdef HEXW_TERM_EN
                // Register already holds the digits right-justified.
                if (base_cnt != 4'd0)
                    state_d = HOLD;
`else
                // Terminators carry no meaning in this build.
                state_d = state_d;
`endif
            end else begin
                err_d  = 1'b1;
                word_d = '0;
                cnt_d  = 4'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            word_q  <= '0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.word_valid  = (state_q == HOLD);
    assign bus.word_data   = word_q;
    assign bus.digit_count = cnt_q;
    assign bus.err_pulse   = err_q;
    assign bus.overrun     = ovr_q;

endmodule

// File: doc/uart_hex_word_assembler.md
Name: uart_hex_word_assembler

Overview:
- Sits directly downstream of uart_rx.
- Consumes the single-cycle byte strobes from uart_rx and decodes ASCII hex characters into 4-bit nibbles.
- Packs NUM_DIGITS nibbles, most significant first, into one word and presents it on a valid/ready handshake to the operand consumer (the RSA datapath / seven-segment display path).
- Flags bad characters and bytes lost while a word is waiting.

Parameters:
- NUM_DIGITS, 8, hex digits per word; legal range 1..8.
- WORD_W, 4*NUM_DIGITS, output word width (derived; do not override).

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous active-high reset
- rx_valid  input  1  one-cycle strobe from uart_rx; rx_data is valid in that cycle
- rx_data  input  8  received ASCII byte
- word_ready  input  1  downstream can take word_data this cycle
- word_valid  output  1  word_data holds a complete word
- word_data  output  WORD_W  assembled word; the first digit received sits in the MSBs
- digit_count  output  4  digits collected for the current word (0..NUM_DIGITS)
- err_pulse  output  1  one-cycle pulse when an illegal character is received
- overrun  output  1  sticky; a byte arrived while in HOLD and was dropped

Behaviour:
- Reset:
  - rst is sampled on the clk edge only.
  - All outputs are 0 and the state is COLLECT.
  - rst mid-word discards any partial word and any pending word.
- Character decode:
  - '0'-'9' (0x30-0x39) decode to 0-9.
  - 'A'-'F' (0x41-0x46) and 'a'-'f' (0x61-0x66) decode to 10-15.
  - CR (0x0D) and LF (0x0A) are terminators; their handling is set under Optional Feature.
  - Every other byte is illegal.
- State COLLECT:
  - On rx_valid with a hex digit: shift register <= {register[WORD_W-5:0], nibble}; digit_count increments.
  - When the increment reaches NUM_DIGITS: go to HOLD and set word_valid = 1 on the next edge.
  - Latency: last-digit strobe in cycle N gives word_valid high in cycle N+1.
  - On rx_valid with an illegal byte: err_pulse = 1 for exactly the next cycle; shift register and digit_count clear to 0; state stays COLLECT.
- State HOLD:
  - word_valid = 1; word_data and digit_count are held stable.
  - Transfer occurs on a clk edge where word_valid & word_ready.
  - After transfer: word_valid = 0, digit_count = 0, register cleared, state returns to COLLECT.
  - rx_valid without word_ready: the byte is dropped, overrun is set (sticky until rst), and the word is unchanged.
  - rx_valid in the same cycle as the transfer: the byte is not dropped. It is processed as the first byte of the next word (digit gives count 1; illegal byte gives err_pulse) and overrun is unchanged.
- word_ready while word_valid = 0 is ignored.
- err_pulse is never asserted for a byte dropped in HOLD.
- digit_count never exceeds NUM_DIGITS.

Optional Feature:
- Macro: HEXW_TERM_EN.
- Defined:
  - CR or LF in COLLECT with digit_count >= 1 completes the word early.
  - The word is the collected digits, right-justified and zero-extended (the register already holds this value). Go to HOLD with the same N+1 latency.
  - CR/LF with digit_count = 0 is ignored (blank lines produce nothing).
- Not defined:
  - CR/LF in COLLECT are silently ignored: no error, no state change.
  - Only NUM_DIGITS digits complete a word.
- In both builds, CR/LF received in HOLD follow the HOLD rules.

Test Plan:
- Reset check: assert rst for 2 cycles, release -> word_valid=0, word_data=0, digit_count=0, overrun=0, err_pulse=0.
- Mixed-case full word: strobe "1a2B3c4D" (8 strobes, gaps of 3 cycles), word_ready=1 -> word_valid high exactly 1 cycle after the 8th strobe, word_data=32'h1A2B3C4D, then word_valid=0 and digit_count=0.
- Illegal character: strobe "12", then 'G' (0x47), then "00000000" -> err_pulse high for 1 cycle after 'G'; the partial word is discarded; final word_data=32'h00000000.
- Hold and overrun: 8 digits "DEADBEEF" with word_ready=0, then strobe '5' -> word_data stays 32'hDEADBEEF and overrun=1. Then raise word_ready -> one transfer, overrun remains 1.
- Same-cycle accept: word pending 32'hCAFEF00D; word_ready=1 and rx_valid with '7' in the same cycle -> transfer completes, digit_count=1 next cycle, overrun=0.
- Terminator, HEXW_TERM_EN defined: strobe "ABC" then CR -> word_data=32'h00000ABC, word_valid asserted 1 cycle after CR. Without the macro: same stimulus -> no word, digit_count=3.
